ecs3_decoder: RTL and testbench

- Streaming decoder for the ECS3 nibble code; inverse of the ECS3 encoder.
- Accepts one 9-bit ECS3 symbol per handshake and reconstructs the 4-bit nibble {A,B,C,D}.
- Packs nibbles LSB-first into NIBBLES*4-bit words behind a valid/ready output.
- Sits at the receive end of the ECS3 compressed link.

---
 rtl/ecs3_pkg.sv | 25 ++
 rtl/ecs3_sym_decode.sv | 37 +++
 rtl/ecs3_decoder.sv | 101 ++++++++++
 tb/tb_ecs3_decoder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecs3_pkg.sv
// Shared ECS3 field widths, position constants and the packed symbol type.
package ecs3_pkg;

  localparam int NOI_W = 2;
  localparam int IND_W = 3;
  localparam int NIB_W = 4;

  localparam logic [IND_W-1:0] POS_NONE = 3'd0;
  localparam logic [IND_W-1:0] POS_D    = 3'd1;
  localparam logic [IND_W-1:0] POS_C    = 3'd2;
  localparam logic [IND_W-1:0] POS_B    = 3'd3;
  localparam logic [IND_W-1:0] POS_A    = 3'd4;

  typedef struct packed {
    logic             flag;
    logic [NOI_W-1:0] noi;
    logic [IND_W-1:0] ind0;
    logic [IND_W-1:0] ind1;
  } ecs3_sym_t;

  function automatic logic pos_valid(input logic [IND_W-1:0] ind);
    return (ind >= POS_D) && (ind <= POS_A);
  endfunction

endpackage

// File: rtl/ecs3_sym_decode.sv
// Combinational ECS3 symbol decoder: nibble reconstruction plus legality flag.
module ecs3_sym_decode
  import ecs3_pkg::*;
(
  input  ecs3_sym_t        sym,
  output logic [NIB_W-1:0] nib,
  output logic             illegal
);

  logic [1:0] bit0;
  logic [1:0] bit1;
  logic       legal;

  always_comb begin
    // Positions 1..4 map to bits 0..3; position 4 wraps to 2'b00 - 1 = 3.
    bit0 = sym.ind0[1:0] - 2'd1;
    bit1 = sym.ind1[1:0] - 2'd1;
    nib  = sym.flag ? {NIB_W{1'b1}} : {NIB_W{1'b0}};
    if ((sym.noi != 2'd0) && pos_valid(sym.ind0))
      nib[bit0] = ~nib[bit0];
    if ((sym.noi >= 2'd2) && pos_valid(sym.ind1))
      nib[bit1] = ~nib[bit1];
  end

  always_comb begin
    legal = 1'b0;
    case (sym.noi)
      2'd0:    legal = (sym.ind0 == POS_NONE) && (sym.ind1 == POS_NONE);
      2'd1:    legal = pos_valid(sym.ind0) && (sym.ind1 == POS_NONE);
      2'd2:    legal = !sym.flag && (sym.ind0 >= POS_D) &&
                       (sym.ind0 < sym.ind1) && (sym.ind1 <= POS_A);
      default: legal = 1'b0;
    endcase
    illegal = !legal;
  end

endmodule

// File: rtl/ecs3_decoder.sv
// ECS3 streaming decoder: decodes symbols to nibbles and packs them LSB-first into words.
// Optional legality checking on err/err_sticky is built when ECS3_ERR_CHK_EN is defined.
module ecs3_decoder
  import ecs3_pkg::*;
#(
  parameter int NIBBLES = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_flag,
  input  logic [NOI_W-1:0]             in_noi,
  input  logic [IND_W-1:0]             in_ind0,
  input  logic [IND_W-1:0]             in_ind1,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NIBBLES*NIB_W-1:0]     out_data,
  output logic [$clog2(NIBBLES+1)-1:0] out_cnt,
  output logic                         out_last,
  output logic                         err,
  output logic                         err_sticky
);

  localparam int W     = NIBBLES * NIB_W;
  localparam int CNT_W = $clog2(NIBBLES + 1);
  localparam int NC_W  = $clog2(NIBBLES);

  ecs3_sym_t        sym;
  logic [NIB_W-1:0] sym_nib;
  logic             sym_illegal;
  logic [NC_W-1:0]  nib_cnt;
  logic [W-1:0]     acc_p0;
  logic [W-1:0]     acc_wr;
  logic             commit_pending;
  logic             accept;

  assign sym = {in_flag, in_noi, in_ind0, in_ind1};

  ecs3_sym_decode u_dec (
    .sym     (sym),
    .nib     (sym_nib),
    .illegal (sym_illegal)
  );

  // Only a committing symbol can collide with an unconsumed output word.
  assign commit_pending = (nib_cnt == NC_W'(NIBBLES - 1)) || in_last;
  assign in_ready       = !(out_valid && !out_ready && commit_pending);
  assign accept         = in_valid && in_ready;

  always_comb begin
    acc_wr = acc_p0;
    acc_wr[int'(nib_cnt)*NIB_W +: NIB_W] = sym_nib;
  end

  // Stage p0: accumulation buffer -> output register
  always_ff @(posedge clk) begin
    if (rst) begin
      nib_cnt   <= '0;
      acc_p0    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
      out_last  <= 1'b0;
    end else if (accept && commit_pending) begin
      out_data  <= acc_wr;
      out_cnt   <= CNT_W'(nib_cnt) + CNT_W'(1);
      out_last  <= in_last;
      out_valid <= 1'b1;
      nib_cnt   <= '0;
      acc_p0    <= '0;
    end else begin
      if (accept) begin
        acc_p0  <= acc_wr;
        nib_cnt <= nib_cnt + NC_W'(1);
      end
      if (out_valid && out_ready)
        out_valid <= 1'b0;
    end
  end

`ifdef ECS3_ERR_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      err <= accept && sym_illegal;
      if (accept && sym_illegal)
        err_sticky <= 1'b1;
    end
  end
`else
  logic unused_illegal;
  assign unused_illegal = sym_illegal;
  assign err            = 1'b0;
  assign err_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_ecs3_decoder.sv
// Self-checking bench for ecs3_decoder: directed scenarios plus randomized traffic vs a queue model.
module tb_ecs3_decoder;

  localparam int N  = 8;
  localparam int W  = N * 4;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_flag = 1'b0;
  logic [1:0]    in_noi = '0;
  logic [2:0]    in_ind0 = '0;
  logic [2:0]    in_ind1 = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_cnt;
  logic          out_last;
  logic          err;
  logic          err_sticky;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [CW-1:0] cnt;
    logic          last;
  } word_t;

  word_t      got_q[$];
  word_t      exp_q[$];
  logic [3:0] nib_q[$];

  ecs3_decoder #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_flag(in_flag), .in_noi(in_noi), .in_ind0(in_ind0), .in_ind1(in_ind1),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_cnt(out_cnt), .out_last(out_last),
    .err(err), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [3:0] ref_nib(input logic f, input logic [1:0] noi,
                                         input logic [2:0] i0, input logic [2:0] i1);
    int v;
    int used;
    v    = f ? 15 : 0;
    used = (noi >= 2) ? 2 : int'(noi);
    if (used >= 1 && i0 >= 1 && i0 <= 4) v = v ^ (1 << (i0 - 1));
    if (used >= 2 && i1 >= 1 && i1 <= 4) v = v ^ (1 << (i1 - 1));
    return v[3:0];
  endfunction

  // Reference model and output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      nib_q.delete();
    end else begin
      if (out_valid && out_ready)
        got_q.push_back('{data: out_data, cnt: out_cnt, last: out_last});
      if (in_valid && in_ready) begin
        nib_q.push_back(ref_nib(in_flag, in_noi, in_ind0, in_ind1));
        if (nib_q.size() == N || in_last) begin
          word_t w;
          w = '0;
          for (int i = 0; i < nib_q.size(); i++)
            w.data = w.data | (W'(nib_q[i]) << (4 * i));
          w.cnt  = CW'(nib_q.size());
          w.last = in_last;
          exp_q.push_back(w);
          nib_q.delete();
        end
      end
    end
  end

  task automatic send_sym(input logic f, input logic [1:0] noi, input logic [2:0] i0,
                          input logic [2:0] i1, input logic last);
    int n;
    in_valid = 1'b1; in_flag = f; in_noi = noi; in_ind0 = i0; in_ind1 = i1; in_last = last;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_cnt !== '0) begin errors++; $display("FAIL reset_out_cnt got=%0d exp=0", out_cnt); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%0b exp=0", out_last); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err_sticky got=%0b exp=0", err_sticky); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    send_sym(0, 1, 1, 0, 0); send_sym(0, 1, 2, 0, 0);
    send_sym(0, 2, 1, 2, 0); send_sym(0, 1, 3, 0, 0);
    send_sym(0, 2, 1, 3, 0); send_sym(0, 2, 2, 3, 0);
    send_sym(1, 1, 4, 0, 0); send_sym(0, 1, 4, 0, 0);
    idle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid got=%0b exp=1", out_valid); end
    checks++; if (out_data !== 32'h87654321) begin errors++; $display("FAIL stream_data got=%h exp=87654321", out_data); end
    checks++; if (out_cnt !== CW'(8)) begin errors++; $display("FAIL stream_cnt got=%0d exp=8", out_cnt); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL stream_last got=%0b exp=0", out_last); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL stream_err_sticky got=%0b exp=0", err_sticky); end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [3:0] nb [16];
    word_t wa;
    for (int i = 0; i < 16; i++) nb[i] = 4'($urandom_range(0, 15));
    out_ready = 1'b0;
    // Raw nibble as flag=0 with up to two distinct set positions is not general; use flag + toggles.
    for (int i = 0; i < 8; i++) send_sym(1'b0, 2'd0, 3'd0, 3'd0, 1'b0);
    for (int i = 0; i < 7; i++) send_sym(1'b1, 2'd1, 3'(1 + (i % 4)), 3'd0, 1'b0);
    wa = exp_q[exp_q.size()-1];
    in_valid = 1'b1; in_flag = 1'b0; in_noi = 2'd1; in_ind0 = 3'(1 + (nb[0] % 4)); in_ind1 = 3'd0; in_last = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall in_ready got=%0b exp=0", in_ready); end
    checks++; if (out_data !== wa.data) begin errors++; $display("FAIL bp_hold out_data got=%h exp=%h", out_data, wa.data); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release in_ready got=%0b exp=1", in_ready); end
    @(posedge clk); #1;
    idle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_nobubble out_valid got=%0b exp=1", out_valid); end
    checks++; if (out_data !== exp_q[exp_q.size()-1].data) begin errors++; $display("FAIL bp_next_data got=%h exp=%h", out_data, exp_q[exp_q.size()-1].data); end
    checks++; if (out_cnt !== CW'(8)) begin errors++; $display("FAIL bp_next_cnt got=%0d exp=8", out_cnt); end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_last();
    out_ready = 1'b1;
    send_sym(1, 0, 0, 0, 0); send_sym(1, 1, 3, 0, 0); send_sym(0, 2, 2, 3, 1);
    idle();
    checks++; if (out_data !== 32'h000006BF) begin errors++; $display("FAIL last_data got=%h exp=000006bf", out_data); end
    checks++; if (out_cnt !== CW'(3)) begin errors++; $display("FAIL last_cnt got=%0d exp=3", out_cnt); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL last_flag got=%0b exp=1", out_last); end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    logic exp_err;
`ifdef ECS3_ERR_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    out_ready = 1'b1;
    send_sym(1, 2, 1, 2, 1);
    idle();
    checks++; if (err !== exp_err) begin errors++; $display("FAIL illegal_err got=%0b exp=%0b", err, exp_err); end
    checks++; if (err_sticky !== exp_err) begin errors++; $display("FAIL illegal_sticky got=%0b exp=%0b", err_sticky, exp_err); end
    checks++; if (out_data !== 32'h0000000C) begin errors++; $display("FAIL illegal_data got=%h exp=0000000c", out_data); end
    @(posedge clk); #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL illegal_err_pulse got=%0b exp=0", err); end
    checks++; if (err_sticky !== exp_err) begin errors++; $display("FAIL illegal_sticky_hold got=%0b exp=%0b", err_sticky, exp_err); end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_midreset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_sym(0, 1, 3'(1 + i % 4), 0, 0);
    idle();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got=%0b exp=0", out_valid); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL mrst_sticky got=%0b exp=0", err_sticky); end
    for (int i = 0; i < 8; i++) send_sym(1, 0, 0, 0, 0);
    idle();
    checks++; if (out_data !== 32'hFFFFFFFF) begin errors++; $display("FAIL mrst_data got=%h exp=ffffffff", out_data); end
    checks++; if (out_cnt !== CW'(8)) begin errors++; $display("FAIL mrst_cnt got=%0d exp=8", out_cnt); end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send_sym(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0));
          if ($urandom_range(0, 7) == 0) begin idle(); @(posedge clk); #1; end
        end
        send_sym(0, 0, 0, 0, 1);
        idle();
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
  endtask

  task automatic test_scoreboard();
    int n;
    word_t g;
    word_t e;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 200) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL sb_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL sb_word got=%h/%0d/%0b exp=%h/%0d/%0b", g.data, g.cnt, g.last, e.data, e.cnt, e.last);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_last();
    test_illegal();
    test_scoreboard();
    test_midreset();
    test_random();
    test_scoreboard();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
